// File: rtl/udma_ethernet_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the Ethernet MAC TX byte stream, with a programmable inter-frame gap.
// Define ETH_TX_ARB_PRIO_EN to give requester 0 strict priority over the round-robin group.
module udma_ethernet_tx_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int IFG_W = 4
) (
  input  logic               sys_clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic [IFG_W-1:0]   ifg_cycles_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_sof_i,
  input  logic [N_REQ-1:0]   req_eof_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  output logic               tx_sof_o,
  output logic               tx_eof_o,
  input  logic               tx_ready_i,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               sof_err_o
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [IFG_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [N_REQ-1:0] cand, flush;
  logic [ID_W:0]    rr_res;
  logic             prio0, pick_vld, upd_ptr;
  logic [ID_W-1:0]  pick_id;

  // First set bit of mask strictly after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] sel;
    int              idx;
    res = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = ID_W'(idx);
      if (mask[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  assign cand  = req_valid_i & req_sof_i;
  assign flush = req_valid_i & ~req_sof_i;

`ifdef ETH_TX_ARB_PRIO_EN
  localparam logic [N_REQ-1:0] OTHERS = ~N_REQ'(1);
  assign prio0  = cand[0];
  assign rr_res = rr_pick(cand & OTHERS, rr_ptr);
`else
  assign prio0  = 1'b0;
  assign rr_res = rr_pick(cand, rr_ptr);
`endif

  assign pick_vld = prio0 | rr_res[ID_W];
  assign pick_id  = prio0 ? '0 : rr_res[ID_W-1:0];
  assign upd_ptr  = ~prio0;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(N_REQ-1);
      grant_id_o <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_id_o <= grant_nxt;
      gap_cnt    <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_id_o;
    gap_cnt_nxt  = gap_cnt;
    req_ready_o  = '0;
    tx_data_o    = '0;
    tx_valid_o   = 1'b0;
    tx_sof_o     = 1'b0;
    tx_eof_o     = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    sof_err_o    = 1'b0;
    case (state)
      IDLE: begin
        // Stray mid-frame beats are drained here; held off while reset is asserted.
        if (rstn_i) begin
          req_ready_o = flush;
          sof_err_o   = |flush;
        end
        if (en_i && pick_vld) begin
          grant_nxt = pick_id;
          if (upd_ptr) rr_ptr_nxt = pick_id;
          state_nxt = XFER;
        end
      end
      XFER: begin
        busy_o                  = 1'b1;
        tx_data_o               = req_data_i[8*grant_id_o +: 8];
        tx_valid_o              = req_valid_i[grant_id_o];
        tx_sof_o                = req_sof_i[grant_id_o];
        tx_eof_o                = req_eof_i[grant_id_o];
        req_ready_o[grant_id_o] = tx_ready_i;
        if (tx_valid_o && tx_ready_i && tx_eof_o) begin
          frame_done_o = 1'b1;
          if (ifg_cycles_i != '0) begin
            gap_cnt_nxt = ifg_cycles_i;
            state_nxt   = GAP;
          end else begin
            state_nxt   = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt - IFG_W'(1);
        if (gap_cnt <= IFG_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_udma_ethernet_tx_arbiter.sv
// Scoreboard bench for udma_ethernet_tx_arbiter: frame-level scheduling model feeds an expected-beat queue.
`timescale 1ns/1ps
module tb_udma_ethernet_tx_arbiter;
  localparam int N  = 2;
  localparam int IW = 1;
  localparam int FW = 4;
`ifdef ETH_TX_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic [FW-1:0] ifg = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_sof = '0;
  logic [N-1:0]  req_eof = '0;
  logic [N-1:0]  req_ready;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_sof, tx_eof;
  logic          tx_ready = 1'b1;
  logic [IW-1:0] grant_id;
  logic          busy, frame_done, sof_err;

  int total = 0;
  int bad   = 0;

  // beat = {sof, eof, data}; expected entry = {grant, beat}
  logic [9:0]  srcq [N][$];
  logic [9:0]  mq   [N][$];
  logic [10:0] expq [$];
  logic [10:0] e;
  logic [N-1:0] hs_q = '0;
  logic [N-1:0] m;
  int  mptr = N-1;
  bit  rnd_ready = 1'b0;
  bit  gap_chk = 1'b0;
  bit  wait_sof = 1'b0;
  int  exp_gap = 0, cyc = 0, eof_cyc = 0, nbeats = 0, fd_cnt = 0, gap_cnt = 0;

  always #5 clk = ~clk;

  udma_ethernet_tx_arbiter #(.N_REQ(N), .ID_W(IW), .IFG_W(FW)) dut (
    .sys_clk_i(clk), .rstn_i(rstn), .en_i(en), .ifg_cycles_i(ifg),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_sof_i(req_sof), .req_eof_i(req_eof),
    .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_sof_o(tx_sof),
    .tx_eof_o(tx_eof), .tx_ready_i(tx_ready), .grant_id_o(grant_id), .busy_o(busy),
    .frame_done_o(frame_done), .sof_err_o(sof_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_frame(input int k, input int len);
    logic [9:0] b;
    for (int i = 0; i < len; i++) begin
      b = {i == 0, i == len-1, 8'($urandom_range(0, 255))};
      srcq[k].push_back(b);
      mq[k].push_back(b);
    end
  endtask

  // All loaded frames are pending at once, so each grant goes to the next requester
  // after the last round-robin winner that still has frames (req 0 first in priority mode).
  task automatic plan();
    int k;
    int c;
    bit p;
    logic [9:0] b;
    while (mq[0].size() + mq[1].size() > 0) begin
      k = -1;
      p = 1'b0;
      if (PRIO && mq[0].size() > 0) begin
        k = 0;
        p = 1'b1;
      end
      for (int i = 1; i <= N; i++) begin
        c = (mptr + i) % N;
        if (k < 0 && mq[c].size() > 0) k = c;
      end
      if (!p) mptr = k;
      do begin
        b = mq[k].pop_front();
        expq.push_back({k[0], b});
      end while (!b[8]);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = budget;
    while (expq.size() > 0 && n > 0) begin
      @(negedge clk);
      n--;
    end
    check({name, "_drain"}, 64'(expq.size()), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) hs_q <= req_valid & req_ready;

  // Requester sources: present the head beat, advance on handshake
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs_q[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      if (srcq[k].size() > 0) begin
        req_valid[k] = 1'b1;
        {req_sof[k], req_eof[k], req_data[8*k +: 8]} = srcq[k][0];
      end else begin
        req_valid[k] = 1'b0;
        req_sof[k]   = 1'b0;
        req_eof[k]   = 1'b0;
      end
    end
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rstn) begin
      if (busy) begin
        m = '0;
        m[grant_id] = tx_ready;
        check("ready_mask", 64'(req_ready), 64'(m));
      end
      check("frame_done", 64'(frame_done), 64'(tx_valid & tx_ready & tx_eof));
      if (frame_done) fd_cnt++;
      if (!gap_chk) wait_sof = 1'b0;
      if (tx_valid && wait_sof) begin
        check("ifg_gap", 64'(cyc - eof_cyc - 1), 64'(exp_gap + 1));
        gap_cnt++;
        wait_sof = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        nbeats++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat: got unexpected beat %0h from grant %0d, expected none", tx_data, grant_id);
        end else begin
          e = expq.pop_front();
          check("beat", 64'({grant_id, tx_sof, tx_eof, tx_data}), 64'(e));
        end
        if (tx_eof) begin
          eof_cyc  = cyc;
          wait_sof = gap_chk;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, gc0, nb0, n, viol;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({tx_valid, tx_sof, tx_eof, tx_data, req_ready, grant_id, busy, frame_done, sof_err}), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'({tx_valid, busy, req_ready, grant_id}), 64'(0));

    // Both requesters present a 4-byte frame together
    en = 1'b1; ifg = '0; exp_gap = 0;
    fd0 = fd_cnt;
    add_frame(0, 4);
    add_frame(1, 4);
    plan();
    gap_chk = 1'b1;
    wait_done("basic", 200);
    check("basic_frame_done_cnt", 64'(fd_cnt - fd0), 64'(2));

    // Back-to-back frames from req0 with a 12-cycle gap
    gap_chk = 1'b0;
    repeat (2) @(negedge clk);
    ifg = 4'd12; exp_gap = 12;
    fd0 = fd_cnt; gc0 = gap_cnt;
    for (int f = 0; f < 3; f++) add_frame(0, $urandom_range(2, 5));
    plan();
    gap_chk = 1'b1;
    wait_done("ifg12", 400);
    check("ifg12_frames", 64'(fd_cnt - fd0), 64'(3));
    check("ifg12_gaps_seen", 64'(gap_cnt - gc0), 64'(2));

    // Random frames with backpressure
    rnd_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      gap_chk = 1'b0;
      repeat (20) @(negedge clk);
      ifg = FW'($urandom_range(0, 3));
      exp_gap = int'(ifg);
      for (int k = 0; k < N; k++) begin
        n = $urandom_range(1, 3);
        for (int f = 0; f < n; f++) add_frame(k, $urandom_range(1, 6));
      end
      plan();
      gap_chk = 1'b1;
      wait_done("random", 800);
    end

    // IDLE flush of non-SOF beats
    rnd_ready = 1'b0;
    gap_chk = 1'b0;
    repeat (20) @(negedge clk);
    srcq[1].push_back({1'b0, 1'b0, 8'h5a});
    @(negedge clk);
    check("flush_ready", 64'(req_ready), 64'(2'b10));
    check("flush_err", 64'(sof_err), 64'(1));
    check("flush_no_tx", 64'(tx_valid), 64'(0));
    @(negedge clk);
    check("flush_err_once", 64'(sof_err), 64'(0));
    check("flush_dropped", 64'(srcq[1].size()), 64'(0));
    en = 1'b0;
    srcq[0].push_back({1'b0, 1'b1, 8'h11});
    srcq[1].push_back({1'b0, 1'b0, 8'h22});
    @(negedge clk);
    check("flush2_ready", 64'(req_ready), 64'(2'b11));
    check("flush2_err", 64'(sof_err), 64'(1));
    @(negedge clk);
    check("flush2_err_once", 64'(sof_err), 64'(0));

    // Enable dropped mid-frame
    repeat (4) @(negedge clk);
    rnd_ready = 1'b1; ifg = 4'd1;
    for (int k = 0; k < N; k++) begin
      add_frame(k, 6);
      add_frame(k, 6);
    end
    plan();
    en = 1'b1;
    n = 50;
    do begin
      @(negedge clk);
      n--;
    end while (!busy && n > 0);
    check("en_busy_seen", 64'(busy), 64'(1));
    en = 1'b0;
    fd0 = fd_cnt;
    n = 200;
    do begin
      @(negedge clk);
      n--;
    end while (!frame_done && n > 0);
    check("en_frame_completes", 64'(frame_done), 64'(1));
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || busy) viol++;
    end
    check("en_low_no_grant", 64'(viol), 64'(0));
    check("en_low_one_frame", 64'(fd_cnt - fd0), 64'(1));
    en = 1'b1;
    wait_done("en_resume", 800);

    // Asynchronous reset mid-frame
    repeat (10) @(negedge clk);
    rnd_ready = 1'b0; ifg = '0;
    add_frame(0, 10);
    plan();
    nb0 = nbeats;
    n = 100;
    while (nbeats < nb0 + 3 && n > 0) begin
      @(negedge clk);
      n--;
    end
    check("midreset_started", 64'(nbeats >= nb0 + 3), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    check("midreset_outputs", 64'({tx_valid, tx_sof, tx_eof, tx_data, req_ready, grant_id, busy, frame_done, sof_err}), 64'(0));
    expq.delete();
    for (int k = 0; k < N; k++) begin
      srcq[k].delete();
      mq[k].delete();
    end
    mptr = N-1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Both requesting continuously after reset: arbitration restarts from req0
    rnd_ready = 1'b1; ifg = 4'd2; exp_gap = 2;
    for (int f = 0; f < 3; f++) begin
      add_frame(0, $urandom_range(1, 5));
      add_frame(1, $urandom_range(1, 5));
    end
    plan();
    gap_chk = 1'b1;
    wait_done("contend", 800);
    gap_chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
